qrst_cmd_ctrl: RTL and testbench
================================

Name: qrst_cmd_ctrl

Overview:
- Command front-end directly upstream of the QICK reset synchronizer (cmd_sync) in the xcom path.
- Accepts decoded xcom control commands and issues level-held reset requests (now / on-sync), closing the four-phase handshake against the synchronizer's ack.
- Also generates the periodic sync pulse the synchronizer waits on, with a programmable period.
- Reports done and timeout status to the register/status logic.

Parameters:
- PW, 16: width of the sync period register and counter.
- PER_DEF, 1000: sync period in t_clk_i cycles after reset.
- PULSE_HI, 4: pulse_sync_o high time in cycles. Must be ≥3 so it survives the downstream 2-FF synchronizer plus edge detect.
- TO_W, 16: timeout counter width.
- TO_CYC, 4096: handshake timeout in cycles, 1..2^TO_W-1.

Ports:
- t_clk_i  in  1  clock
- t_rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_op_i  in  2  0=NOP, 1=RST_NOW, 2=RST_SYNC, 3=SET_PERIOD
- cmd_data_i  in  PW  new period (SET_PERIOD only)
- cmd_ready_o  out  1  command accepted when valid & ready
- qrst_now_req_o  out  1  immediate-reset request, level
- qrst_sync_req_o  out  1  sync-aligned reset request, level
- qrst_ack_i  in  1  ack from synchronizer
- pulse_sync_o  out  1  periodic sync pulse
- busy_o  out  1  handshake in progress
- done_o  out  1  1-cycle pulse on command completion
- timeout_o  out  1  sticky handshake-timeout flag

Behaviour:
- Reset (async): FSM=IDLE; all outputs 0 except the period register, which loads PER_DEF. Sync counter=0, timeout counter=0.
- All outputs are registered except cmd_ready_o.
- cmd_ready_o = (state==IDLE) & !qrst_ack_i, combinational.

FSM states: IDLE, REQ, REL.

IDLE: on accept at cycle N:
- RST_NOW: qrst_now_req_o=1 from N+1; go to REQ.
- RST_SYNC: qrst_sync_req_o=1 from N+1; go to REQ.
- SET_PERIOD: period register ← cmd_data_i and sync counter ← 0 at N+1; done_o at N+1; stay IDLE.
- NOP: done_o at N+1; stay IDLE.
- Any accept clears timeout_o at N+1.

REQ: hold the request.
- qrst_ack_i sampled 1 at cycle M: both reqs 0 at M+1; go to REL.

REL: wait for the synchronizer to finish (ack stays high through its wait-sync and execute phases).
- qrst_ack_i sampled 0 at cycle K: go to IDLE; done_o=1 at K+1.

Never more than one of qrst_now_req_o / qrst_sync_req_o is high.

busy_o = (state != IDLE).

Timeout:
- Counter cleared on entering REQ; increments in REQ and REL.
- In the cycle it equals TO_CYC-1 without the exit condition: next cycle go to IDLE, reqs 0, timeout_o=1, no done_o.
- Exit condition and timeout in the same cycle: the exit condition wins.

Sync pulse generator:
- Free-running counter 0..P-1, where P is the effective period.
- pulse_sync_o = registered (cnt < PULSE_HI).
- Period 0: generator disabled, cnt held at 0, pulse_sync_o=0.
- Period 1..2*PULSE_HI-1: effective P = 2*PULSE_HI (clamped).
- Counter wraps P-1 → 0.
- SET_PERIOD restarts at cnt=0, so the pulse restarts on the next cycle.
- The generator runs independently of the FSM.

Other rules:
- Commands arriving while not ready stay pending; the upstream holds valid, with no drop or queue inside this block.
- Reset mid-handshake: reqs drop immediately (async). The downstream must be reset by the same t_rst_ni.

Test Plan:
- RST_NOW accepted at cycle 10; bench acks at cycle 13 and releases at 21 → qrst_now_req_o high for cycles 11–13; done_o at 22; cmd_ready_o 0 for cycles 11–21.
- SET_PERIOD data=20, then RST_SYNC with the synchronizer model acking on req and releasing 8 cycles after the next pulse_sync_o edge → pulse high 4 cycles every 20; done_o follows release; qrst_sync_req_o never overlaps qrst_now_req_o.
- RST_SYNC with period 0 and the model never dropping ack; TO_CYC=64 → return to IDLE 64 cycles after entering REQ; timeout_o=1; no done_o; a subsequent NOP clears timeout_o.
- SET_PERIOD data=3 with PULSE_HI=4 → effective period 8 (4 high / 4 low); data=0 → pulse stays low.
- cmd_valid_i held with qrst_ack_i forced high while IDLE → cmd_ready_o=0, no request issued. Release ack → accepted the same cycle.
- Assert t_rst_ni low mid-REQ → reqs, busy_o and pulse_sync_o go 0 asynchronously; period register returns to PER_DEF.

Source files
------------

// File: rtl/qrst_cmd_ctrl.sv
// Command front-end for the QICK reset synchronizer: issues level-held reset
// requests closed by a four-phase ack handshake, and generates the periodic sync pulse.
module qrst_cmd_ctrl #(
    parameter int unsigned PW       = 16,
    parameter int unsigned PER_DEF  = 1000,
    parameter int unsigned PULSE_HI = 4,
    parameter int unsigned TO_W     = 16,
    parameter int unsigned TO_CYC   = 4096
) (
    input  logic          t_clk_i,
    input  logic          t_rst_ni,
    input  logic          cmd_valid_i,
    input  logic [1:0]    cmd_op_i,
    input  logic [PW-1:0] cmd_data_i,
    output logic          cmd_ready_o,
    output logic          qrst_now_req_o,
    output logic          qrst_sync_req_o,
    input  logic          qrst_ack_i,
    output logic          pulse_sync_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_o
);

    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;
    typedef enum logic [1:0] {
        OP_NOP        = 2'd0,
        OP_RST_NOW    = 2'd1,
        OP_RST_SYNC   = 2'd2,
        OP_SET_PERIOD = 2'd3
    } op_t;

    localparam logic [PW-1:0]   PER_RST = PW'(PER_DEF);
    localparam logic [PW-1:0]   MIN_PER = PW'(2 * PULSE_HI);
    localparam logic [PW-1:0]   HI_CNT  = PW'(PULSE_HI);
    localparam logic [PW-1:0]   PER_ONE = PW'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    state_t          state;
    op_t             op;
    logic            accept;
    logic            set_period;
    logic            to_hit;
    logic [TO_W-1:0] to_cnt;
    logic [PW-1:0]   period;
    logic [PW-1:0]   eff_period;
    logic [PW-1:0]   sync_cnt;

    assign cmd_ready_o = (state == IDLE) && !qrst_ack_i;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign op          = op_t'(cmd_op_i);
    assign set_period  = accept && (op == OP_SET_PERIOD);
    assign to_hit      = (to_cnt == TO_LAST);
    assign busy_o      = (state != IDLE);

    // Short non-zero periods are stretched so the low phase is never shorter than the high phase.
    assign eff_period  = (period < MIN_PER) ? MIN_PER : period;

    always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
        if (!t_rst_ni) begin
            state           <= IDLE;
            qrst_now_req_o  <= 1'b0;
            qrst_sync_req_o <= 1'b0;
            done_o          <= 1'b0;
            timeout_o       <= 1'b0;
            to_cnt          <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        timeout_o <= 1'b0;
                        to_cnt    <= '0;
                        case (op)
                            OP_RST_NOW: begin
                                qrst_now_req_o <= 1'b1;
                                state          <= REQ;
                            end
                            OP_RST_SYNC: begin
                                qrst_sync_req_o <= 1'b1;
                                state           <= REQ;
                            end
                            default: done_o <= 1'b1;
                        endcase
                    end
                end
                REQ: begin
                    to_cnt <= to_cnt + TO_ONE;
                    // The ack is checked first so it wins over a coincident timeout.
                    if (qrst_ack_i) begin
                        qrst_now_req_o  <= 1'b0;
                        qrst_sync_req_o <= 1'b0;
                        state           <= REL;
                    end else if (to_hit) begin
                        qrst_now_req_o  <= 1'b0;
                        qrst_sync_req_o <= 1'b0;
                        timeout_o       <= 1'b1;
                        state           <= IDLE;
                    end
                end
                REL: begin
                    to_cnt <= to_cnt + TO_ONE;
                    if (!qrst_ack_i) begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end else if (to_hit) begin
                        timeout_o <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
        if (!t_rst_ni) begin
            period       <= PER_RST;
            sync_cnt     <= '0;
            pulse_sync_o <= 1'b0;
        end else begin
            pulse_sync_o <= (period != '0) && (sync_cnt < HI_CNT);
            if (set_period) begin
                period   <= cmd_data_i;
                sync_cnt <= '0;
            end else if ((period == '0) || (sync_cnt >= eff_period - PER_ONE)) begin
                sync_cnt <= '0;
            end else begin
                sync_cnt <= sync_cnt + PER_ONE;
            end
        end
    end

endmodule

// File: tb/tb_qrst_cmd_ctrl.sv
// Bench for qrst_cmd_ctrl: table of period settings plus hand-written handshake,
// timeout and reset sequences; completion events are checked against a scoreboard queue.
module tb_qrst_cmd_ctrl;

    localparam int PW       = 16;
    localparam int PER_DEF  = 12;
    localparam int PULSE_HI = 4;
    localparam int TO_W     = 16;
    localparam int TO_CYC   = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = '0;
    logic [PW-1:0] cmd_data = '0;
    logic          ack = 1'b0;
    logic          cmd_ready, now_req, sync_req, pulse, busy, done, timeout;

    always #5 clk = ~clk;

    qrst_cmd_ctrl #(
        .PW(PW), .PER_DEF(PER_DEF), .PULSE_HI(PULSE_HI), .TO_W(TO_W), .TO_CYC(TO_CYC)
    ) dut (
        .t_clk_i(clk),
        .t_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_op_i(cmd_op),
        .cmd_data_i(cmd_data),
        .cmd_ready_o(cmd_ready),
        .qrst_now_req_o(now_req),
        .qrst_sync_req_o(sync_req),
        .qrst_ack_i(ack),
        .pulse_sync_o(pulse),
        .busy_o(busy),
        .done_o(done),
        .timeout_o(timeout)
    );

    typedef enum int {EV_NONE, EV_DONE, EV_TIMEOUT} ev_t;
    typedef struct {
        logic [PW-1:0] data;
        int            per;
    } per_vec_t;

    int       checks = 0;
    int       fails = 0;
    ev_t      expq[$];
    logic     timeout_q = 1'b0;
    per_vec_t tbl[7];
    logic [63:0] v_now, v_sync, v_busy, v_done, v_rdy;
    logic     prev, got;
    int       idle_at, hold_bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_expect(input string name, input ev_t seen);
        ev_t want;
        checks++;
        if (expq.size() == 0) begin
            fails++;
            $display("FAIL %s: got %s, expected no event", name, seen.name());
        end else begin
            want = expq.pop_front();
            if (want != seen) begin
                fails++;
                $display("FAIL %s: got %s, expected %s", name, seen.name(), want.name());
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) pop_expect("done_event", EV_DONE);
            if (timeout && !timeout_q) pop_expect("timeout_event", EV_TIMEOUT);
            if (now_req || sync_req) begin
                checks++;
                if (now_req && sync_req) begin
                    fails++;
                    $display("FAIL req_overlap: got now=1 sync=1, expected at most one");
                end
            end
        end
        timeout_q = timeout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string name, input logic [1:0] op, input logic [PW-1:0] data,
                        input ev_t ev);
        check({name, "_ready"}, 64'(cmd_ready), 64'd1);
        if (ev != EV_NONE) expq.push_back(ev);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
    endtask

    // Expects the sync counter to be 0 just before the next posedge (k=1).
    task automatic train(input string name, input int p, input int n);
        logic [63:0] act, exp;
        act = '0;
        exp = '0;
        for (int k = 1; k <= n; k++) begin
            tick();
            act[k-1] = pulse;
            exp[k-1] = (p != 0) && (((k - 1) % p) < PULSE_HI);
        end
        check(name, act, exp);
    endtask

    initial begin
        tbl[0] = '{data: 16'd3,  per: 8};
        tbl[1] = '{data: 16'd0,  per: 0};
        tbl[2] = '{data: 16'd7,  per: 8};
        tbl[3] = '{data: 16'd1,  per: 8};
        tbl[4] = '{data: 16'd8,  per: 8};
        tbl[5] = '{data: 16'd9,  per: 9};
        tbl[6] = '{data: 16'd20, per: 20};

        // Reset state
        repeat (3) tick();
        check("rst_now_req", 64'(now_req), 64'd0);
        check("rst_sync_req", 64'(sync_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pulse", 64'(pulse), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd1);
        rst_n = 1'b1;
        train("pulse_per_def", PER_DEF, 30);

        // RST_NOW: ack sampled high at A+3, low at A+11
        send("now_cmd", 2'd1, '0, EV_DONE);
        v_now = '0; v_sync = '0; v_busy = '0; v_done = '0; v_rdy = '0;
        v_now[0] = now_req; v_sync[0] = sync_req; v_busy[0] = busy;
        v_done[0] = done; v_rdy[0] = cmd_ready;
        for (int k = 1; k <= 12; k++) begin
            ack = (k >= 3) && (k <= 10);
            tick();
            v_now[k] = now_req; v_sync[k] = sync_req; v_busy[k] = busy;
            v_done[k] = done; v_rdy[k] = cmd_ready;
        end
        check("now_req_window", v_now, 64'h007);
        check("now_sync_quiet", v_sync, 64'h000);
        check("now_busy_window", v_busy, 64'h7FF);
        check("now_done_cycle", v_done, 64'h800);
        check("now_ready_window", v_rdy, 64'h1800);

        // Period table, including clamp boundaries
        for (int i = 0; i < 7; i++) begin
            send($sformatf("setp%0d", i), 2'd3, tbl[i].data, EV_DONE);
            check($sformatf("setp%0d_done", i), 64'(done), 64'd1);
            check($sformatf("setp%0d_busy", i), 64'(busy), 64'd0);
            train($sformatf("setp%0d_pulse", i), tbl[i].per, 60);
        end

        // RST_SYNC against a synchronizer model that releases 8 cycles after a pulse edge
        send("sync_cmd", 2'd2, '0, EV_DONE);
        check("sync_req_on", 64'(sync_req), 64'd1);
        check("sync_now_off", 64'(now_req), 64'd0);
        ack = 1'b1;
        tick();
        check("sync_req_drop", 64'(sync_req), 64'd0);
        check("sync_busy_rel", 64'(busy), 64'd1);
        prev = pulse;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (pulse && !prev) got = 1'b1;
            prev = pulse;
        end
        check("sync_pulse_edge", 64'(got), 64'd1);
        repeat (8) tick();
        check("sync_busy_wait", 64'(busy), 64'd1);
        check("sync_no_early_done", 64'(done), 64'd0);
        ack = 1'b0;
        tick();
        check("sync_done", 64'(done), 64'd1);
        check("sync_idle", 64'(busy), 64'd0);
        tick();
        check("sync_done_single", 64'(done), 64'd0);

        // Timeout with period 0 and ack never released
        send("to_setp0", 2'd3, '0, EV_DONE);
        train("to_pulse_off", 0, 40);
        send("to_sync", 2'd2, '0, EV_TIMEOUT);
        ack = 1'b1;
        idle_at = -1;
        for (int k = 1; k <= 80 && idle_at < 0; k++) begin
            tick();
            if (!busy) idle_at = k;
        end
        check("to_return_cycle", 64'(idle_at), 64'd64);
        check("to_flag", 64'(timeout), 64'd1);
        check("to_no_done", 64'(done), 64'd0);
        check("to_reqs_low", {62'd0, now_req, sync_req}, 64'd0);
        ack = 1'b0;
        tick();
        check("to_sticky", 64'(timeout), 64'd1);
        send("to_nop", 2'd0, '0, EV_DONE);
        check("to_cleared", 64'(timeout), 64'd0);
        check("to_nop_done", 64'(done), 64'd1);

        // Valid held while ack is high in IDLE
        ack = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 2'd1;
        hold_bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (cmd_ready || now_req || busy) hold_bad++;
        end
        check("ackhi_blocked", 64'(hold_bad), 64'd0);
        ack = 1'b0;
        #1;
        check("ackhi_ready_now", 64'(cmd_ready), 64'd1);
        expq.push_back(EV_DONE);
        tick();
        cmd_valid = 1'b0;
        cmd_op = '0;
        check("ackhi_accept", 64'(now_req), 64'd1);
        ack = 1'b1;
        tick();
        check("ackhi_req_drop", 64'(now_req), 64'd0);
        ack = 1'b0;
        tick();
        check("ackhi_done", 64'(done), 64'd1);

        // Asynchronous reset in REQ
        send("rst_setp", 2'd3, 16'd100, EV_DONE);
        send("rst_cmd", 2'd1, '0, EV_NONE);
        check("pre_rst_req", 64'(now_req), 64'd1);
        check("pre_rst_pulse", 64'(pulse), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", {62'd0, now_req, sync_req}, 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_pulse", 64'(pulse), 64'd0);
        expq.delete();
        tick();
        rst_n = 1'b1;
        train("rst_per_def", PER_DEF, 40);

        check("scoreboard_empty", 64'(expq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1);
    end

endmodule
